// File: rtl/pc_fetch_sequencer_if.sv
`timescale 1ns/1ps
// pc_fetch_sequencer_if
// Groups the fetch sequencer's bus signals: PC register feedback and
// control, instruction memory handshake, decode handshake, redirect
// requests and the saved exception state.
//   master : the sequencer side (drives PC control, imem_req, instr_valid,
//            epc, cause, fetch_timeout)
//   slave  : the environment side (PC register, instruction memory,
//            decode and redirect sources)
interface pc_fetch_sequencer_if;
  logic [31:0] pc_address;
  logic        imem_req;
  logic        imem_ack;
  logic        instr_valid;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;
  logic        pc_count;
  logic        pc_use_new;
  logic [31:0] pc_new;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic        fetch_timeout;

  modport master (
    input  pc_address, imem_ack, stall, br_valid, br_target,
           exc_valid, exc_code, eret,
    output imem_req, instr_valid, pc_count, pc_use_new, pc_new,
           epc, cause, fetch_timeout
  );

  modport slave (
    output pc_address, imem_ack, stall, br_valid, br_target,
           exc_valid, exc_code, eret,
    input  imem_req, instr_valid, pc_count, pc_use_new, pc_new,
           epc, cause, fetch_timeout
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
`timescale 1ns/1ps
// pc_fetch_sequencer
// Sequences instruction fetch from a wait-stated instruction memory and
// steers the external PC register (advance / redirect / hold). Redirect
// sources are prioritised exception > eret > branch/jump; a redirect that
// arrives while a fetch is outstanding is parked in a one-entry pending
// slot and applied when the memory acknowledges (the fetched word is then
// squashed). A fetched instruction that decode cannot accept is held.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : pc_fetch_sequencer_if.master (PC, imem, decode, redirect, EPC)
//
// Parameters:
//   EXC_VECTOR   : exception handler address
//   MAX_WAIT     : wait-cycle limit before a fetch timeout
//   TIMEOUT_CODE : cause recorded on a fetch timeout
//
// Build option:
//   PC_SEQ_TIMEOUT_EN : when defined, a fetch that waits MAX_WAIT cycles
//   without ack is abandoned and a timeout exception is taken. When
//   undefined, FETCH waits indefinitely and fetch_timeout is tied low.
//
// PC control, instr_valid and imem_req are combinational from state and
// inputs; epc, cause and fetch_timeout are registered.
module pc_fetch_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
  parameter int unsigned MAX_WAIT     = 15,
  parameter logic [4:0]  TIMEOUT_CODE = 5'd6
) (
  input logic                   clk,
  input logic                   rst,
  pc_fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_exc_q, pend_exc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;

  // Same-cycle request, already priority-resolved.
  logic        req_valid;
  logic        req_exc;
  logic [31:0] req_target;
  // Request merged with the pending entry: the redirect to act on now.
  logic        redir_valid;
  logic        redir_exc;
  logic [31:0] redir_target;

  logic        timeout_hit;

  logic        imem_req_w;
  logic        instr_valid_w;
  logic        pc_count_w;
  logic        pc_use_new_w;
  logic [31:0] pc_new_w;

  always_comb begin
    req_valid  = bus.exc_valid | bus.eret | bus.br_valid;
    req_exc    = bus.exc_valid;
    req_target = bus.br_target;
    if (bus.exc_valid) begin
      req_target = EXC_VECTOR;
    end else if (bus.eret) begin
      req_target = epc_q;
    end
  end

  // A parked exception is never displaced by a lower-priority request.
  logic keep_pend;
  logic take_new;
  always_comb begin
    keep_pend    = pend_valid_q & pend_exc_q & ~req_exc;
    take_new     = req_valid & ~keep_pend;
    redir_valid  = take_new | pend_valid_q;
    redir_exc    = take_new ? req_exc    : pend_exc_q;
    redir_target = take_new ? req_target : pend_target_q;
  end

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int CW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          fetch_timeout_q;

  // Fires in the wait cycle that would bring the counter up to MAX_WAIT,
  // so the redirect lands exactly MAX_WAIT unacknowledged cycles in.
  assign timeout_hit = (state_q == FETCH) && !bus.imem_ack &&
                       (wait_cnt_q == CW'(MAX_WAIT - 1));

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == FETCH && !bus.imem_ack && !timeout_hit) begin
      wait_cnt_d = (wait_cnt_q == {CW{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q      <= '0;
      fetch_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q      <= wait_cnt_d;
      fetch_timeout_q <= timeout_hit;
    end
  end

  assign bus.fetch_timeout = fetch_timeout_q;
`else
  assign timeout_hit       = 1'b0;
  assign bus.fetch_timeout = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_WAIT)};
`endif

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_exc_d    = pend_exc_q;
    pend_target_d = pend_target_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    imem_req_w    = 1'b0;
    instr_valid_w = 1'b0;
    pc_count_w    = 1'b0;
    pc_use_new_w  = 1'b0;
    pc_new_w      = '0;

    // Exception state is captured on the request edge, whatever the state.
    if (bus.exc_valid) begin
      epc_d   = bus.pc_address;
      cause_d = bus.exc_code;
    end

    case (state_q)
      BOOT: begin
        pend_valid_d  = redir_valid;
        pend_exc_d    = redir_exc;
        pend_target_d = redir_target;
        state_d       = FETCH;
      end

      FETCH: begin
        imem_req_w = 1'b1;
        if (timeout_hit) begin
          // Abandoned fetch becomes an exception; it outranks anything parked.
          pc_use_new_w = 1'b1;
          pc_new_w     = EXC_VECTOR;
          epc_d        = bus.pc_address;
          cause_d      = TIMEOUT_CODE;
          pend_valid_d = 1'b0;
          pend_exc_d   = 1'b0;
        end else if (!bus.imem_ack) begin
          pend_valid_d  = redir_valid;
          pend_exc_d    = redir_exc;
          pend_target_d = redir_target;
        end else if (redir_valid) begin
          // Returned word belongs to the old path: squash it.
          pc_use_new_w = 1'b1;
          pc_new_w     = redir_target;
          pend_valid_d = 1'b0;
          pend_exc_d   = 1'b0;
        end else begin
          instr_valid_w = 1'b1;
          if (bus.stall) begin
            state_d = HOLD;
          end else begin
            pc_count_w = 1'b1;
          end
        end
      end

      HOLD: begin
        instr_valid_w = 1'b1;
        if (redir_valid) begin
          instr_valid_w = 1'b0;
          pc_use_new_w  = 1'b1;
          pc_new_w      = redir_target;
          pend_valid_d  = 1'b0;
          pend_exc_d    = 1'b0;
          state_d       = FETCH;
        end else if (!bus.stall) begin
          pc_count_w = 1'b1;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pend_valid_q  <= 1'b0;
      pend_exc_q    <= 1'b0;
      pend_target_q <= '0;
      epc_q         <= '0;
      cause_q       <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_exc_q    <= pend_exc_d;
      pend_target_q <= pend_target_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
    end
  end

  assign bus.imem_req    = imem_req_w;
  assign bus.instr_valid = instr_valid_w;
  assign bus.pc_count    = pc_count_w;
  assign bus.pc_use_new  = pc_use_new_w;
  assign bus.pc_new      = pc_new_w;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controls the program counter and sequences instruction fetch from a wait-stated instruction memory.
- Drives the PC's count, use-new-PC and new-PC controls.
- Arbitrates redirect sources by priority: exception > eret > branch/jump > sequential.
- Keeps EPC/cause state and holds fetched instructions under pipeline stall.

Parameters:
EXC_VECTOR, 32'h80000180, exception handler address loaded on exception or fetch timeout
MAX_WAIT, 15, fetch wait-cycle limit before a fetch timeout (only with PC_SEQ_TIMEOUT_EN)
TIMEOUT_CODE, 5'd6, cause value recorded on fetch timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
pc_address  in  32  current PC from the PC register
imem_req  out  1  fetch request to instruction memory at pc_address
imem_ack  in  1  instruction memory data valid this cycle
instr_valid  out  1  fetched instruction valid to decode
stall  in  1  decode cannot accept an instruction
br_valid  in  1  branch/jump taken request, single-cycle pulse
br_target  in  32  branch/jump target
exc_valid  in  1  exception request, single-cycle pulse
exc_code  in  5  exception cause code
eret  in  1  return-from-exception pulse
pc_count  out  1  PC adds 4 this cycle
pc_use_new  out  1  PC loads pc_new
pc_new  out  32  redirect target
epc  out  32  saved exception PC
cause  out  5  saved exception cause
fetch_timeout  out  1  one-cycle pulse on fetch timeout

Behaviour:
- PC control encoding:
  - advance: pc_count=1, pc_use_new=0
  - redirect: pc_use_new=1, pc_count=0, pc_new=target; PC equals target on the next cycle
  - hold: both 0
- Reset (rst=0, async): state BOOT; all outputs 0; epc=0, cause=0, pending redirect cleared, wait counter 0. Outputs are combinational from state and inputs except epc, cause and fetch_timeout, which are registered.
- Redirect resolution within a cycle:
  - exc_valid wins: target EXC_VECTOR; epc<=pc_address and cause<=exc_code at that clock edge.
  - else eret: target = current epc.
  - else br_valid: target br_target.
  - exc and eret in the same cycle: exception taken, eret dropped.
- Pending redirect: one entry holding valid, target and priority.
  - A new request overwrites the entry unless the entry is an exception and the new request is not.
  - A same-cycle request is merged by the same rule before use.
- BOOT: 1 cycle; imem_req=0, PC hold; then go to FETCH.
- FETCH: imem_req=1.
  - No ack: PC hold; capture any redirect into pending; increment wait counter.
  - Ack with pending/same-cycle redirect: apply redirect; instr_valid=0 (squash); clear pending and counter; stay in FETCH.
  - Ack with no redirect and stall=0: instr_valid=1, advance; stay in FETCH.
  - Ack with no redirect and stall=1: instr_valid=1, PC hold; go to HOLD.
- HOLD: imem_req=0, instr_valid=1, PC hold.
  - Redirect: apply immediately; instr_valid=0; go to FETCH.
  - Else stall=0: advance; go to FETCH.
- Wait counter: 4 bits minimum, saturating, sized to hold MAX_WAIT.
- Reset mid-fetch: abandon the request immediately; memory must drop any outstanding access when imem_req falls.

Optional Feature:
PC_SEQ_TIMEOUT_EN
- Defined:
  - When the wait counter reaches MAX_WAIT in FETCH with no ack, the fetch is abandoned.
  - A timeout exception is taken: epc<=pc_address, cause<=TIMEOUT_CODE, redirect to EXC_VECTOR, instr_valid=0.
  - fetch_timeout pulses for 1 cycle, the counter clears, and the state stays FETCH.
  - The timeout overrides any pending non-exception redirect.
- Not defined: FETCH waits indefinitely; fetch_timeout is tied to 0; no counter logic is built.

Test Plan:
- Reset release with pc_address=0x00400000 and imem_ack tied high, stall=0 -> BOOT 1 cycle, then pc_count=1 every cycle; addresses step 0x00400000, 0x00400004, 0x00400008.
- br_valid=1 with br_target=0x00400100 during a 3-cycle wait state -> pending captured; on ack pc_use_new=1, pc_new=0x00400100, instr_valid=0; next fetch at 0x00400100.
- exc_valid and br_valid in the same cycle, exc_code=5'd4, pc_address=0x00400020 -> pc_new=0x80000180, epc=0x00400020, cause=4; later eret -> pc_new=0x00400020.
- Ack with stall=1 held 4 cycles -> HOLD, instr_valid=1 for 5 cycles, PC constant, imem_req=0; stall drops -> pc_count=1, back to FETCH.
- With PC_SEQ_TIMEOUT_EN, MAX_WAIT=15, no ack at pc_address=0x00400040 -> after 15 cycles fetch_timeout=1 for 1 cycle, cause=6, epc=0x00400040, pc_new=0x80000180.
- rst asserted mid-FETCH wait -> imem_req, pc_count, pc_use_new, instr_valid=0 immediately; epc=0, cause=0; pending redirect discarded after release.
